// File: rtl/get_r_inverse_pkg.sv
// Shared constants, FSM encoding and result saturation for the R^-1 stage
// and the downstream get_R_inv_mult_H stage.
package get_r_inverse_pkg;

  localparam int FRAC_BITS = 16;
  localparam int DIV_ITER  = 32;
  localparam int OUT_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DET,
    S_LOAD,
    S_DIV,
    S_STORE,
    S_DONE
  } state_e;

  // Apply the sign to an unsigned quotient magnitude and clamp to the signed range.
  function automatic logic [OUT_W-1:0] sat_signed(input logic neg, input logic [OUT_W-1:0] mag);
    logic [OUT_W-1:0] res;
    if (neg) begin
      res = (mag[OUT_W-1] && (mag[OUT_W-2:0] != '0)) ? {1'b1, {(OUT_W-1){1'b0}}} : -mag;
    end else begin
      res = mag[OUT_W-1] ? {1'b0, {(OUT_W-1){1'b1}}} : mag;
    end
    return res;
  endfunction

endpackage

// File: rtl/get_r_inverse_serial_divider_u32.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle after start.
module serial_divider_u32 #(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rem_q;
  logic [31:0]   quo_q;
  logic [31:0]   div_q;
  logic [32:0]   remShift;
  logic [32:0]   diff;

  always_comb begin
    remShift = {rem_q, quo_q[31]};
    diff     = remShift - {1'b0, div_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      div_q  <= divisor_i;
    end else if (busy_q) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= remShift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(ITER - 1)) busy_q <= 1'b0;
    end
  end

  // done_o marks the final iteration; the quotient is complete on the next cycle.
  assign done_o     = busy_q && (cnt_q == CW'(ITER - 1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/get_r_inverse.sv
// 2x2 matrix inverse in Q15.16: exact determinant, then four serial divisions
// of the adjugate elements sharing one divider.
module get_r_inverse #(
  parameter int FRAC_BITS = get_r_inverse_pkg::FRAC_BITS,
  parameter int DIV_ITER  = get_r_inverse_pkg::DIV_ITER
) (
  input  logic                                I_sys_clk,
  input  logic                                I_sys_rstn,
  input  logic                                I_start,
  input  logic [15:0]                         I_R11,
  input  logic [15:0]                         I_R12,
  input  logic [15:0]                         I_R21,
  input  logic [15:0]                         I_R22,
  output logic                                O_busy,
  output logic                                O_done,
  output logic                                O_singular,
  output logic [get_r_inverse_pkg::OUT_W-1:0] O_R11_inv,
  output logic [get_r_inverse_pkg::OUT_W-1:0] O_R12_inv,
  output logic [get_r_inverse_pkg::OUT_W-1:0] O_R21_inv,
  output logic [get_r_inverse_pkg::OUT_W-1:0] O_R22_inv
);

  import get_r_inverse_pkg::*;

  state_e             state_q, state_d;
  logic signed [15:0] r11_q, r12_q, r21_q, r22_q;
  logic signed [31:0] prodA, prodB;
  logic signed [32:0] detNow, det_q;
  logic [1:0]         idx_q;
  logic [OUT_W-1:0]   res0_q, res1_q, res2_q;
  logic [OUT_W-1:0]   inv11_q, inv12_q, inv21_q, inv22_q;
  logic               singular_q;
  logic signed [16:0] adj;
  logic [16:0]        adjMag;
  logic [31:0]        detMag, dividend, quotient;
  logic [OUT_W-1:0]   resultNow;
  logic               divStart, divDone, negRes;

  always_comb begin
    prodA  = r11_q * r22_q;
    prodB  = r12_q * r21_q;
    detNow = {prodA[31], prodA} - {prodB[31], prodB};
    unique case (idx_q)
      2'd0:    adj = {r22_q[15], r22_q};
      2'd1:    adj = -{r12_q[15], r12_q};
      2'd2:    adj = -{r21_q[15], r21_q};
      default: adj = {r11_q[15], r11_q};
    endcase
    adjMag    = adj[16] ? -adj : adj;
    dividend  = 32'(adjMag) << FRAC_BITS;
    detMag    = det_q[32] ? 32'(-det_q) : 32'(det_q);
    negRes    = adj[16] ^ det_q[32];
    resultNow = sat_signed(negRes, quotient);
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_start) state_d = S_DET;
      S_DET:   state_d = (detNow == '0) ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_DIV;
      S_DIV:   if (divDone) state_d = S_STORE;
      S_STORE: state_d = (idx_q == 2'd3) ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_busy   = (state_q != S_IDLE);
    O_done   = (state_q == S_DONE);
    divStart = (state_q == S_LOAD);
  end

  // Outputs change only on entry to DONE, so they stay coherent between operations.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r11_q <= '0; r12_q <= '0; r21_q <= '0; r22_q <= '0;
      det_q <= '0;
      idx_q <= '0;
      res0_q <= '0; res1_q <= '0; res2_q <= '0;
      inv11_q <= '0; inv12_q <= '0; inv21_q <= '0; inv22_q <= '0;
      singular_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (I_start) begin
          r11_q <= I_R11; r12_q <= I_R12; r21_q <= I_R21; r22_q <= I_R22;
        end
        S_DET: begin
          det_q <= detNow;
          idx_q <= '0;
          if (detNow == '0) begin
            inv11_q <= '0; inv12_q <= '0; inv21_q <= '0; inv22_q <= '0;
            singular_q <= 1'b1;
          end
        end
        S_STORE: begin
          idx_q <= idx_q + 2'd1;
          unique case (idx_q)
            2'd0: res0_q <= resultNow;
            2'd1: res1_q <= resultNow;
            2'd2: res2_q <= resultNow;
            default: begin
              inv11_q <= res0_q; inv12_q <= res1_q; inv21_q <= res2_q;
              inv22_q <= resultNow;
              singular_q <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  serial_divider_u32 #(.ITER(DIV_ITER)) u_div (
    .clk_i      (I_sys_clk),
    .rst_ni     (I_sys_rstn),
    .start_i    (divStart),
    .dividend_i (dividend),
    .divisor_i  (detMag),
    .done_o     (divDone),
    .quotient_o (quotient)
  );

  assign O_R11_inv  = inv11_q;
  assign O_R12_inv  = inv12_q;
  assign O_R21_inv  = inv21_q;
  assign O_R22_inv  = inv22_q;
  assign O_singular = singular_q;

endmodule

// File: tb/tb_get_r_inverse.sv
// Directed-vector bench for get_r_inverse: timing, values, singular, saturation,
// ignored start and mid-operation reset.
module tb_get_r_inverse;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] r11, r12, r21, r22;
  logic        busy, done, singular;
  logic [31:0] inv11, inv12, inv21, inv22;

  int checkCount = 0;
  int passCount  = 0;

  get_r_inverse dut (
    .I_sys_clk  (clk),
    .I_sys_rstn (rstn),
    .I_start    (start),
    .I_R11      (r11),
    .I_R12      (r12),
    .I_R21      (r21),
    .I_R22      (r22),
    .O_busy     (busy),
    .O_done     (done),
    .O_singular (singular),
    .O_R11_inv  (inv11),
    .O_R12_inv  (inv12),
    .O_R21_inv  (inv21),
    .O_R22_inv  (inv22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Presents R with start, waits for the accepting edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [15:0] a, b, c, d);
    r11 = a; r12 = b; r21 = c; r22 = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r11 = 16'h5A5A; r12 = 16'hA5A5; r21 = 16'h1234; r22 = 16'h7FFF;
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, b, c, d,
                       input logic [31:0] e11, e12, e21, e22,
                       input logic expSing, input int expLat, input int injectAt);
    int n;
    int busyCnt;
    bit seen;
    applyStimulus(a, b, c, d);
    n = 0; busyCnt = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (n == injectAt) begin
        start = 1'b1; r11 = 16'd2; r12 = 16'd1; r21 = 16'd1; r22 = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) busyCnt++;
      if (done) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, seen ? n : -1, expLat);
    checkOutput({tag, ".busyCycles"}, busyCnt, expLat);
    checkOutput({tag, ".R11inv"}, inv11, e11);
    checkOutput({tag, ".R12inv"}, inv12, e12);
    checkOutput({tag, ".R21inv"}, inv21, e21);
    checkOutput({tag, ".R22inv"}, inv22, e22);
    checkOutput({tag, ".singular"}, {31'b0, singular}, {31'b0, expSing});
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, ".busyAfter"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, ".hold"}, inv22, e22);
  endtask

  initial begin
    int doneSeen;
    rstn = 1'b0; start = 1'b0;
    r11 = '0; r12 = '0; r21 = '0; r22 = '0;
    #1;
    checkOutput("reset.busy", {31'b0, busy}, 32'd0);
    checkOutput("reset.done", {31'b0, done}, 32'd0);
    checkOutput("reset.singular", {31'b0, singular}, 32'd0);
    checkOutput("reset.R11inv", inv11, 32'd0);
    checkOutput("reset.R21inv", inv21, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    runOp("diag", 16'd256, 16'd0, 16'd0, 16'd256,
          32'h00000100, 32'h00000000, 32'h00000000, 32'h00000100, 1'b0, 138, 0);
    runOp("unitDet", 16'd2, 16'd1, 16'd1, 16'd1,
          32'h00010000, 32'hFFFF0000, 32'hFFFF0000, 32'h00020000, 1'b0, 138, 0);
    runOp("singular", 16'd2, 16'd4, 16'd1, 16'd2,
          32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2, 0);
    runOp("saturate", 16'd1, 16'd1, 16'h8001, 16'h8000,
          32'h7FFFFFFF, 32'h00010000, 32'h80010000, 32'hFFFF0000, 1'b0, 138, 0);
    runOp("ignoredStart", 16'd256, 16'd0, 16'd0, 16'd256,
          32'h00000100, 32'h00000000, 32'h00000000, 32'h00000100, 1'b0, 138, 50);

    applyStimulus(16'd2, 16'd1, 16'd1, 16'd1);
    repeat (70) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midReset.busy", {31'b0, busy}, 32'd0);
    checkOutput("midReset.done", {31'b0, done}, 32'd0);
    checkOutput("midReset.R11inv", inv11, 32'd0);
    checkOutput("midReset.R22inv", inv22, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    doneSeen = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midReset.noDone", doneSeen, 32'd0);

    runOp("afterReset", 16'd3, 16'd1, 16'd2, 16'd4,
          32'h00006666, 32'hFFFFE667, 32'hFFFFCCCD, 32'h00004CCC, 1'b0, 138, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/get_r_inverse.md
GET_R_INVERSE -- requirements
Module: get_R_inverse

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, meaning fractional bits of each output (Q15.16).
REQ-002 SHALL have parameter DIV_ITER, default 32, meaning divider iterations per element.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 SHALL have port I_sys_clk, input, 1 bit: system clock, rising edge.
REQ-005 SHALL have port I_sys_rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port I_start, input, 1 bit: start request, sampled only in IDLE.
REQ-007 SHALL have ports I_R11, I_R12, I_R21, I_R22, input, 16 bits each: signed integer elements of the 2x2 matrix R.
REQ-008 SHALL have port O_busy, input-side status output, 1 bit: high from the cycle after start is accepted until the cycle O_done is high, inclusive.
REQ-009 SHALL have port O_done, output, 1 bit: one-cycle pulse when the outputs are valid; this pulse drives the downstream I_get_inverse_ena.
REQ-010 SHALL have port O_singular, output, 1 bit: det(R)==0 for the last completed operation.
REQ-011 SHALL have ports O_R11_inv, O_R12_inv, O_R21_inv, O_R22_inv, output, 32 bits each: signed Q15.16 elements of R^-1.

Function
REQ-012 SHALL capture I_R11..I_R22 on the edge that accepts I_start; later input changes SHALL have no effect on the running operation.
REQ-013 SHALL ignore I_start while O_busy is high.
REQ-014 SHALL implement the states IDLE, DET, LOAD, DIV, STORE and DONE.
REQ-015 SHALL follow these transitions: IDLE->DET on I_start; DET->DONE if det==0, else DET->LOAD; LOAD->DIV; DIV->STORE after DIV_ITER cycles; STORE->LOAD for elements 0..2; STORE->DONE after element 3; DONE->IDLE.
REQ-016 SHALL compute det = R11*R22 - R12*R21 exactly in 33-bit signed arithmetic during DET.
REQ-017 SHALL process the adjugate elements in the order adj11=R22, adj12=-R12, adj21=-R21, adj22=R11, each 17-bit signed.
REQ-018 SHALL compute each output as trunc_toward_zero(adj*2^FRAC_BITS/det), using unsigned division of |adj|<<FRAC_BITS by |det| with sign = sign(adj) XOR sign(det).
REQ-019 SHALL saturate each signed result to the range 0x80000000..0x7FFFFFFF.
REQ-020 SHALL take 1 cycle for LOAD, DIV_ITER cycles for DIV (restoring, one quotient bit per cycle) and 1 cycle for STORE per element.
REQ-021 SHALL assert O_done exactly 138 cycles after the accepting edge for nonsingular R.
REQ-022 SHALL, when det==0, skip all division, drive all four outputs to 0, set O_singular=1 and assert O_done 2 cycles after the accepting edge.
REQ-023 SHALL update all four outputs and O_singular together in DONE and hold them until the next DONE.
REQ-024 SHALL accept a start on the cycle following DONE (back-to-back operation).

Reset
REQ-025 SHALL, on I_sys_rstn low, immediately force state IDLE, O_busy=0, O_done=0, O_singular=0 and all O_R*_inv=0, including when reset arrives mid-operation.
REQ-026 SHALL, after reset is released, produce no O_done until a new start has been accepted.

Structure
REQ-027 SHALL place FRAC_BITS, DIV_ITER, the state encoding and the output width (32) in a shared package used by this block and the downstream get_R_inv_mult_H stage.
REQ-028 SHALL instantiate exactly one sub-module, serial_divider_u32 (32-bit unsigned restoring divider with start/done), reused for all four elements.

Verification
REQ-029 SHALL cover the diagonal case: R=[256,0;0,256] -> O_R11_inv=O_R22_inv=0x00000100, off-diagonal outputs 0, O_singular=0, O_done at +138.
REQ-030 SHALL cover the unit-determinant case: R=[2,1;1,1] (det=1) -> outputs 0x00010000, 0xFFFF0000, 0xFFFF0000, 0x00020000.
REQ-031 SHALL cover the singular case: R=[2,4;1,2] -> all outputs 0, O_singular=1, O_done at +2, O_busy high for exactly 2 cycles.
REQ-032 SHALL cover saturation: R=[1,1;-32767,-32768] (det=-1) -> O_R11_inv=0x7FFFFFFF, O_R12_inv=0x00010000, O_R21_inv=0x80010000, O_R22_inv=0xFFFF0000.
REQ-033 SHALL cover an ignored start: a second I_start pulse with new R at +50 -> no effect on the results or timing of the first operation.
REQ-034 SHALL cover reset mid-operation: assert reset at +70 -> all outputs 0 immediately; no O_done occurs; the next start completes with correct values at +138.
